// File: rtl/imem_loader.sv
// Boot loader: framed byte stream into byte-wide instruction memory, CPU held in reset until done.
// Optional trailing checksum byte enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [31:0]       word_o,
  output logic              word_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_rst_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_LOAD,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [15:0]       r_len;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [23:0]       r_shift;
  logic [31:0]       r_word;
  logic              r_wv;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic          w_acc;
  logic [15:0]   w_n;
  logic          w_len_bad;
  logic [CW-1:0] w_cnt_nx;
  logic          w_last;

  assign w_acc     = byte_valid_i & byte_ready_o;
  assign w_n       = {byte_i[7:0], r_len[7:0]};
  assign w_len_bad = ({1'b0, w_n} > CAP) || (w_n[1:0] != 2'b00);
  assign w_cnt_nx  = r_cnt + 1'b1;
  // N <= 2^ADDR_W is enforced up front, so the count never wraps
  assign w_last    = ({{(16-CW){1'b0}}, w_cnt_nx} == r_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (start_i) w_state_nx = S_LEN0;
      S_LEN0:
        if (w_acc) w_state_nx = S_LEN1;
      S_LEN1:
        if (w_acc) begin
          if (w_n == 16'd0)   w_state_nx = S_DONE;
          else if (w_len_bad) w_state_nx = S_ERR;
          else                w_state_nx = S_LOAD;
        end
      S_LOAD:
        if (w_acc && w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nx = S_CSUM;
`else
          w_state_nx = S_DONE;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:
        if (w_acc) begin
          if (8'(r_sum + byte_i[7:0]) == 8'd0) w_state_nx = S_DONE;
          else                                 w_state_nx = S_ERR;
        end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    unique case (r_state)
      S_LEN0, S_LEN1, S_LOAD: byte_ready_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: byte_ready_o = 1'b1;
`endif
      default: byte_ready_o = 1'b0;
    endcase
  end

  assign busy_o    = byte_ready_o;
  assign done_o    = (r_state == S_DONE);
  assign err_o     = (r_state == S_ERR);
  assign cpu_rst_o = (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_wv    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      r_wv <= 1'b0;
      if (r_state == S_LEN0 && w_acc)
        r_len[7:0] <= byte_i[7:0];
      if (r_state == S_LEN1 && w_acc) begin
        r_len[15:8] <= byte_i[7:0];
        r_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum       <= '0;
`endif
      end
      if (r_state == S_LOAD && w_acc) begin
        r_we    <= 1'b1;
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= byte_i;
        r_cnt   <= w_cnt_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum   <= r_sum + byte_i[7:0];
`endif
        unique case (r_cnt[1:0])
          2'd0: r_shift[7:0]   <= byte_i[7:0];
          2'd1: r_shift[15:8]  <= byte_i[7:0];
          2'd2: r_shift[23:16] <= byte_i[7:0];
          default: begin
            r_word <= {byte_i[7:0], r_shift};
            r_wv   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign word_o       = r_word;
  assign word_valid_o = r_wv;

endmodule
